dmem_lsu: RTL and testbench

// Load/store initiator between the core datapath and the word-addressed DMEM responder.
// - Accepts byte/half/word requests on a valid/ready handshake.
// - Byte address in; word index out to DMEM.
// - Sub-word stores are done as read-modify-write, because DMEM has no byte enables.
// - All DMEM strobes are registered. DMEM writes on the rising edge of its write strobe,
//   so address and data are stable a full cycle before that edge and a full cycle after it.

---
 rtl/lsu_pkg.sv | 21 ++
 rtl/lsu_align.sv | 52 +++++
 rtl/dmem_lsu.sv | 155 +++++++++++++++
 tb/tb_dmem_lsu.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and state type for the DMEM load/store unit.
// Imported by lsu_align and dmem_lsu.
package lsu_pkg;

    localparam int WORD_W = 32;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_X = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        W_SETUP,
        W_PULSE,
        W_HOLD,
        RESP
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Lane extract/extend for loads, lane merge for sub-word stores,
// and size/alignment error detection.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    input  logic [1:0]        addr_lo,
    input  logic [WORD_W-1:0] wdata,
    input  logic [WORD_W-1:0] rword,
    output logic [WORD_W-1:0] load_data,
    output logic [WORD_W-1:0] merged,
    output logic              align_err
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        sx;

    always_comb begin
        byte_v    = rword[{addr_lo, 3'b000} +: 8];
        half_v    = addr_lo[1] ? rword[31:16] : rword[15:0];
        sx        = 1'b0;
        load_data = '0;
        merged    = rword;
        case (size)
            SIZE_B: begin
                sx        = ~is_unsigned & byte_v[7];
                load_data = {{24{sx}}, byte_v};
                merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            SIZE_H: begin
                sx        = ~is_unsigned & half_v[15];
                load_data = {{16{sx}}, half_v};
                merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            end
            SIZE_W: begin
                load_data = rword;
                merged    = wdata;
            end
            default: begin
                load_data = '0;
                merged    = rword;
            end
        endcase
    end

    assign align_err = (size == SIZE_X)
                     | ((size == SIZE_H) & addr_lo[0])
                     | ((size == SIZE_W) & (addr_lo != 2'b00));

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator for the word-addressed DMEM; sub-word stores
// are read-modify-write and every DMEM strobe comes from a register.
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic [31:0]       dmem_address,
    output logic [31:0]       dmem_data_in,
    output logic              dmem_mem_write,
    output logic              dmem_mem_read,
    input  logic [31:0]       dmem_data_out
);

    lsu_state_t        state;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [1:0]        addr_lo_q;
    logic [WORD_W-1:0] wdata_q;

    logic              idle;
    logic [1:0]        a_size;
    logic              a_uns;
    logic [1:0]        a_addr_lo;
    logic [WORD_W-1:0] a_wdata;
    logic [WORD_W-1:0] load_data;
    logic [WORD_W-1:0] merged;
    logic              align_err;
    logic              range_err;
    logic              bad;
    logic              need_rd;

    // In IDLE the aligner checks the incoming request; afterwards it
    // works on the captured copy.
    assign idle      = (state == IDLE);
    assign a_size    = idle ? req_size        : size_q;
    assign a_uns     = idle ? req_unsigned    : uns_q;
    assign a_addr_lo = idle ? req_addr[1:0]   : addr_lo_q;
    assign a_wdata   = idle ? req_wdata       : wdata_q;

    assign range_err = {2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS);
    assign bad       = align_err | range_err;
    assign need_rd   = ~req_we | (req_size != SIZE_W);

    lsu_align u_align (
        .size        (a_size),
        .is_unsigned (a_uns),
        .addr_lo     (a_addr_lo),
        .wdata       (a_wdata),
        .rword       (dmem_data_out),
        .load_data   (load_data),
        .merged      (merged),
        .align_err   (align_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            we_q           <= 1'b0;
            size_q         <= '0;
            uns_q          <= 1'b0;
            addr_lo_q      <= '0;
            wdata_q        <= '0;
            req_ready      <= 1'b0;
            resp_valid     <= 1'b0;
            resp_err       <= 1'b0;
            resp_rdata     <= '0;
            dmem_address   <= '0;
            dmem_data_in   <= '0;
            dmem_mem_write <= 1'b0;
            dmem_mem_read  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        we_q      <= req_we;
                        size_q    <= req_size;
                        uns_q     <= req_unsigned;
                        addr_lo_q <= req_addr[1:0];
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        if (bad) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            dmem_address <= {2'b00, req_addr[31:2]};
                            if (need_rd) begin
                                state         <= RD;
                                dmem_mem_read <= 1'b1;
                            end else begin
                                state        <= W_SETUP;
                                dmem_data_in <= req_wdata;
                            end
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                RD: begin
                    dmem_mem_read <= 1'b0;
                    if (we_q) begin
                        dmem_data_in <= merged;
                        state        <= W_SETUP;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= load_data;
                        state      <= RESP;
                    end
                end
                W_SETUP: begin
                    dmem_mem_write <= 1'b1;
                    state          <= W_PULSE;
                end
                W_PULSE: begin
                    dmem_mem_write <= 1'b0;
                    state          <= W_HOLD;
                end
                W_HOLD: begin
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    state      <= RESP;
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a behavioural DMEM and a response
// scoreboard.
module tb_dmem_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] dmem_address;
    logic [31:0] dmem_data_in;
    logic        dmem_mem_write;
    logic        dmem_mem_read;
    logic [31:0] dmem_data_out;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [256];
    int          n_cmp;
    int          n_bad;
    int          n_wr;
    int          n_rd;

    dmem_lsu #(.DEPTH_WORDS(256)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_err       (resp_err),
        .resp_rdata     (resp_rdata),
        .dmem_address   (dmem_address),
        .dmem_data_in   (dmem_data_in),
        .dmem_mem_write (dmem_mem_write),
        .dmem_mem_read  (dmem_mem_read),
        .dmem_data_out  (dmem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DMEM: writes on the rising edge of its strobe, reads combinationally.
    always @(posedge dmem_mem_write) begin
        mem[dmem_address[7:0]] = dmem_data_in;
        n_wr++;
    end
    assign dmem_data_out = dmem_mem_read ? mem[dmem_address[7:0]] : 32'h0;

    always @(posedge clk) if (rst_n && dmem_mem_read) n_rd++;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && dmem_mem_write)
            check("rd_wr_overlap", {31'd0, dmem_mem_read}, 32'd0);
        if (rst_n && resp_valid) begin
            if (sb.size() == 0) begin
                check("sb_empty", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                check("resp_rdata", resp_rdata, e.rdata);
            end
        end
    end

    task automatic wait_ready();
        int k;
        k = 0;
        @(negedge clk);
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic drive(input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr,
                         input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wdata = 32'h0;
    endtask

    task automatic do_req(input string tag, input logic we,
                          input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic err, input logic [31:0] rdata,
                          input int lat);
        exp_t e;
        int   k;
        wait_ready();
        e.err   = err;
        e.rdata = rdata;
        sb.push_back(e);
        drive(we, size, uns, addr, wdata);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!resp_valid && k < 20);
        check({tag, "_latency"}, k, lat);
    endtask

    initial begin
        int wr0;
        int rd0;
        n_cmp = 0;
        n_bad = 0;
        n_wr  = 0;
        n_rd  = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[4]       = 32'hDEADBEEF;
        mem[8]       = 32'h11223344;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;

        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_strobes", {30'd0, dmem_mem_write, dmem_mem_read}, 32'd0);
        check("rst_address", dmem_address, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {31'd0, req_ready}, 32'd1);

        rd0 = n_rd;
        do_req("lw_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2);
        check("lw_10_reads", n_rd - rd0, 32'd1);

        mem[4] = 32'h80FF_EE11;
        do_req("lb_13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, 32'hFFFFFF80, 2);
        do_req("lbu_13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0, 32'h00000080, 2);
        do_req("lh_12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, 32'hFFFF80FF, 2);
        do_req("lhu_10", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b0, 32'h0000EE11, 2);
        do_req("lb_10", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b0, 32'h00000011, 2);

        wr0 = n_wr;
        do_req("sb_21", 1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA, 1'b0, 32'h0, 5);
        check("sb_21_pulses", n_wr - wr0, 32'd1);
        check("sb_21_mem", mem[8], 32'h1122AA44);
        do_req("sh_22", 1'b1, 2'b01, 1'b0, 32'h22, 32'h1234BEEF, 1'b0, 32'h0, 5);
        check("sh_22_mem", mem[8], 32'hBEEFAA44);

        wr0 = n_wr;
        rd0 = n_rd;
        do_req("sh_03", 1'b1, 2'b01, 1'b0, 32'h03, 32'hFFFF, 1'b1, 32'h0, 1);
        do_req("lw_400", 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 1'b1, 32'h0, 1);
        do_req("sz_11", 1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 1'b1, 32'h0, 1);
        do_req("lw_06", 1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1'b1, 32'h0, 1);
        check("err_no_writes", n_wr - wr0, 32'd0);
        check("err_no_reads", n_rd - rd0, 32'd0);
        do_req("lw_3fc", 1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 1'b0, 32'h0, 2);

        do_req("sw_00", 1'b1, 2'b10, 1'b0, 32'h0, 32'h5, 1'b0, 32'h0, 4);
        do_req("lw_00", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, 32'h5, 2);

        // Address/data must hold through W_SETUP, W_PULSE and W_HOLD.
        wait_ready();
        begin
            exp_t e;
            e.err   = 1'b0;
            e.rdata = 32'h0;
            sb.push_back(e);
        end
        drive(1'b1, 2'b10, 1'b0, 32'h44, 32'h12345678);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("sw_44_addr", dmem_address, 32'h11);
            check("sw_44_data", dmem_data_in, 32'h12345678);
        end
        repeat (3) @(negedge clk);
        check("sw_44_mem", mem[17], 32'h12345678);

        // Reset landing in W_SETUP must abort the store.
        wr0 = n_wr;
        wait_ready();
        drive(1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFEF00D);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_strobes", {30'd0, dmem_mem_write, dmem_mem_read}, 32'd0);
        check("arst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
        check("arst_ready", {31'd0, req_ready}, 32'd0);
        check("arst_addr", dmem_address, 32'd0);
        check("arst_data", dmem_data_in, 32'd0);
        check("arst_rdata", resp_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_ready_after", {31'd0, req_ready}, 32'd1);
        check("arst_no_write", n_wr - wr0, 32'd0);
        check("arst_mem", mem[12], 32'h0);
        do_req("lw_30", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b0, 32'h0, 2);

        repeat (4) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
